mem_ctrl: RTL and testbench

- Memory-side responder for the Processor memory port: oMemAddr/oMemData/oMemRead/oMemWrite in, iMemData/iMemRdy out.
- Holds a single unified word RAM for instructions and data.
- Applies a configurable wait-state latency and a 4-phase ready handshake, replacing the zero-latency behavioural memory used in benches.
- Flags illegal requests (out-of-range address, read and write strobes both high).

---
 rtl/mem_ctrl_if.sv | 24 ++
 rtl/mem_ctrl.sv | 129 ++++++++++++
 tb/tb_mem_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Processor memory-port bundle between a requester (master) and mem_ctrl (slave).
interface mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] iAddr;
    logic [DATA_W-1:0] iData;
    logic              iRead;
    logic              iWrite;
    logic [DATA_W-1:0] oData;
    logic              oRdy;
    logic              oErr;
    logic              oBusy;

    modport master (
        output iAddr, iData, iRead, iWrite,
        input  oData, oRdy, oErr, oBusy
    );

    modport slave (
        input  iAddr, iData, iRead, iWrite,
        output oData, oRdy, oErr, oBusy
    );
endinterface

// File: rtl/mem_ctrl.sv
// Unified word RAM responder with programmable wait states, a one-cycle ready
// pulse and a release handshake that prevents a held strobe from re-triggering.
module mem_ctrl #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 2,
    parameter string       INIT_FILE   = ""
) (
    input logic      iClk,
    input logic      iRst,
    mem_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE, HOLD} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rdata_q;

    logic              req_c;
    logic              commit_c;
    logic              oob_c;
    logic              mem_we_c;
    logic              mem_re_c;
    logic              zero_c;

    logic [DATA_W-1:0] mem [DEPTH];

    assign req_c = bus.iRead | bus.iWrite;
    assign oob_c = (addr_q >= ADDR_W'(DEPTH));

    // Next-state and latched-request logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        err_d    = err_q;
        commit_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_c) begin
                    addr_d  = bus.iAddr;
                    wdata_d = bus.iData;
                    rd_d    = bus.iRead;
                    wr_d    = bus.iWrite;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    commit_c = 1'b1;
                    err_d    = oob_c | (rd_q & wr_q);
                    state_d  = DONE;
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = req_c ? HOLD : IDLE;
            end
            HOLD: begin
                if (!req_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rdy_d  = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    // Illegal requests never touch the RAM; out-of-range reads return zero
    assign mem_we_c = commit_c & wr_q & ~rd_q & ~oob_c & ~iRst;
    assign mem_re_c = commit_c & rd_q & ~wr_q & ~oob_c;
    assign zero_c   = commit_c & oob_c;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

    // Synchronous single-port RAM; contents survive reset
    always_ff @(posedge iClk) begin
        if (mem_we_c) mem[addr_q[IDX_W-1:0]] <= wdata_q;
    end

    always_ff @(posedge iClk) begin
        if (iRst)          rdata_q <= '0;
        else if (mem_re_c) rdata_q <= mem[addr_q[IDX_W-1:0]];
        else if (zero_c)   rdata_q <= '0;
    end

    assign bus.oData = rdata_q;
    assign bus.oRdy  = rdy_q;
    assign bus.oErr  = err_q;
    assign bus.oBusy = busy_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed table, handshake corner cases, reset abort and
// randomized accesses against a word-array model, at WAIT_STATES of 2 and 0.
module tb_mem_ctrl;
    localparam int unsigned DEPTH = 256;

    logic iClk = 1'b0;
    logic rst2, rst0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;

    mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();
    mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

    mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(2), .INIT_FILE(""))
        dut2 (.iClk(iClk), .iRst(rst2), .bus(bus2.slave));
    mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(0), .INIT_FILE(""))
        dut0 (.iClk(iClk), .iRst(rst0), .bus(bus0.slave));

    // Reference model: one word array and last read value per instance
    logic [31:0] model_mem [2][DEPTH];
    logic [31:0] model_rd  [2];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int ws_of(input int w);
        return (w == 0) ? 0 : 2;
    endfunction

    task automatic set_req(input int w, input logic [31:0] a, input logic [31:0] d,
                           input logic r, input logic wr);
        if (w == 0) begin
            bus0.iAddr = a; bus0.iData = d; bus0.iRead = r; bus0.iWrite = wr;
        end else begin
            bus2.iAddr = a; bus2.iData = d; bus2.iRead = r; bus2.iWrite = wr;
        end
    endtask

    function automatic logic get_rdy(input int w);
        return (w == 0) ? bus0.oRdy : bus2.oRdy;
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 0) ? bus0.oBusy : bus2.oBusy;
    endfunction
    function automatic logic get_err(input int w);
        return (w == 0) ? bus0.oErr : bus2.oErr;
    endfunction
    function automatic logic [31:0] get_data(input int w);
        return (w == 0) ? bus0.oData : bus2.oData;
    endfunction

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // One complete access: request, wait for the ready pulse, hold, release
    task automatic access(input int w, input logic [31:0] a, input logic [31:0] d,
                          input logic r, input logic wr, input int hold,
                          output logic [31:0] rdv, output logic erv, output int e0);
        int lat;
        lat = -1;
        rdv = '0;
        erv = 1'b0;
        set_req(w, a, d, r, wr);
        tick();
        e0 = cyc;
        check("busy_after_request", 32'(get_busy(w)), 32'd1);
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            tick();
            if (get_rdy(w)) lat = i;
        end
        if (lat < 0) begin
            check("ready_timeout", 32'd0, 32'd1);
            set_req(w, '0, '0, 1'b0, 1'b0);
            tick();
            return;
        end
        check("ready_latency", 32'(lat), 32'(ws_of(w) + 1));
        rdv = get_data(w);
        erv = get_err(w);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_no_second_ready", 32'(get_rdy(w)), 32'd0);
            check("hold_busy", 32'(get_busy(w)), 32'd1);
        end
        set_req(w, '0, '0, 1'b0, 1'b0);
        tick();
        check("idle_after_release", 32'(get_busy(w)), 32'd0);
        check("ready_single_pulse", 32'(get_rdy(w)), 32'd0);
    endtask

    // Model update from the access rules, then compare against what the DUT showed
    task automatic model_access(input int w, input logic [31:0] a, input logic [31:0] d,
                                input logic r, input logic wr, input int hold);
        logic [31:0] rdv;
        logic        erv;
        logic        exp_err;
        int          e0;
        access(w, a, d, r, wr, hold, rdv, erv, e0);
        exp_err = 1'b0;
        if (a >= DEPTH) begin
            exp_err = 1'b1;
            model_rd[w] = '0;
        end else if (r && wr) begin
            exp_err = 1'b1;
        end else if (wr) begin
            model_mem[w][a] = d;
        end else begin
            model_rd[w] = model_mem[w][a];
        end
        check("model_data", rdv, model_rd[w]);
        check("model_err", 32'(erv), 32'(exp_err));
    endtask

    initial begin
        logic [31:0] rdv;
        logic        erv;
        int          e0;
        int          prev_e0;
        bit          seen_rdy;

        set_req(0, '0, '0, 1'b0, 1'b0);
        set_req(2, '0, '0, 1'b0, 1'b0);
        rst2 = 1'b1;
        rst0 = 1'b1;
        repeat (3) tick();
        rst2 = 1'b0;
        rst0 = 1'b0;
        tick();

        check("reset_rdy", 32'(bus2.oRdy), 32'd0);
        check("reset_err", 32'(bus2.oErr), 32'd0);
        check("reset_busy", 32'(bus2.oBusy), 32'd0);
        check("reset_data", bus2.oData, 32'd0);
        model_rd[0] = '0;
        model_rd[1] = '0;

        // Preload the low 32 words of both RAMs through the port
        for (int i = 0; i < 32; i++) begin
            model_access(0, 32'(i), 32'h1000 + 32'(i), 1'b0, 1'b1, 0);
            model_access(1, 32'(i), 32'h2000 + 32'(i), 1'b0, 1'b1, 0);
        end
        model_access(1, 32'd20, 32'd5, 1'b0, 1'b1, 0);
        model_access(1, 32'd4, 32'h44, 1'b0, 1'b1, 0);

        vecs[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'd20,  data: 32'h0,        exp_data: 32'd5,        exp_err: 1'b0};
        vecs[1] = '{rd: 1'b0, wr: 1'b1, addr: 32'd22,  data: 32'hDEADBEEF, exp_data: 32'd5,        exp_err: 1'b0};
        vecs[2] = '{rd: 1'b1, wr: 1'b0, addr: 32'd22,  data: 32'h0,        exp_data: 32'hDEADBEEF, exp_err: 1'b0};
        vecs[3] = '{rd: 1'b1, wr: 1'b0, addr: 32'd300, data: 32'h0,        exp_data: 32'd0,        exp_err: 1'b1};
        vecs[4] = '{rd: 1'b1, wr: 1'b1, addr: 32'd4,   data: 32'h99,       exp_data: 32'd0,        exp_err: 1'b1};
        vecs[5] = '{rd: 1'b0, wr: 1'b1, addr: 32'd9,   data: 32'hA5A5A5A5, exp_data: 32'd0,        exp_err: 1'b0};
        vecs[6] = '{rd: 1'b1, wr: 1'b0, addr: 32'd9,   data: 32'h0,        exp_data: 32'hA5A5A5A5, exp_err: 1'b0};
        for (int i = 0; i < 7; i++) begin
            access(1, vecs[i].addr, vecs[i].data, vecs[i].rd, vecs[i].wr, 0, rdv, erv, e0);
            check($sformatf("vec%0d_data", i), rdv, vecs[i].exp_data);
            check($sformatf("vec%0d_err", i), 32'(erv), 32'(vecs[i].exp_err));
        end
        model_mem[1][22] = 32'hDEADBEEF;
        model_mem[1][9]  = 32'hA5A5A5A5;
        model_rd[1]      = 32'hA5A5A5A5;
        check("ram22_written", dut2.mem[22], 32'hDEADBEEF);
        check("ram4_unchanged", dut2.mem[4], 32'h44);

        // Write strobe held across completion: one pulse, one write
        access(1, 32'd3, 32'd7, 1'b0, 1'b1, 6, rdv, erv, e0);
        model_mem[1][3] = 32'd7;
        check("held_write_ram3", dut2.mem[3], 32'd7);

        // Reset in the cycle after E1 aborts a pending write
        model_access(1, 32'd5, 32'h55, 1'b0, 1'b1, 0);
        set_req(1, 32'd5, 32'h99, 1'b0, 1'b1);
        seen_rdy = 1'b0;
        tick();
        tick();
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        set_req(1, '0, '0, 1'b0, 1'b0);
        seen_rdy = seen_rdy | bus2.oRdy;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen_rdy = seen_rdy | bus2.oRdy;
        end
        check("abort_no_ready", 32'(seen_rdy), 32'd0);
        check("abort_idle", 32'(bus2.oBusy), 32'd0);
        check("abort_data_cleared", bus2.oData, 32'd0);
        check("abort_ram5", dut2.mem[5], 32'h55);
        model_rd[1] = '0;
        model_access(1, 32'd5, 32'h0, 1'b1, 1'b0, 0);

        // Zero wait states: latency and one access per three cycles
        model_access(0, 32'd0, 32'h11, 1'b0, 1'b1, 0);
        access(0, 32'd0, 32'h0, 1'b1, 1'b0, 0, rdv, erv, e0);
        check("ws0_read_data", rdv, 32'h11);
        model_rd[0] = 32'h11;
        prev_e0 = e0;
        for (int i = 0; i < 6; i++) begin
            model_access(0, 32'(i), 32'h0, 1'b1, 1'b0, 0);
        end
        prev_e0 = -1;
        for (int i = 0; i < 6; i++) begin
            access(0, 32'(i + 8), 32'h0, 1'b1, 1'b0, 0, rdv, erv, e0);
            model_rd[0] = model_mem[0][i + 8];
            check("b2b_data", rdv, model_rd[0]);
            if (prev_e0 >= 0) check("b2b_spacing", 32'(e0 - prev_e0), 32'd3);
            prev_e0 = e0;
        end

        // Randomized accesses on both instances
        for (int n = 0; n < 120; n++) begin
            int          w;
            int          op;
            logic [31:0] a;
            w  = (n % 2 == 0) ? 0 : 1;
            op = int'($urandom_range(0, 9));
            a  = 32'($urandom_range(0, 31));
            if (op == 9) a = 32'(DEPTH) + 32'($urandom_range(0, 40));
            model_access(w, a, $urandom, (op < 4) || (op >= 8), (op >= 4) && (op != 9),
                         int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
